// File: rtl/mold_itch_frontend.sv
// mold_itch_frontend: MoldUDP64 deframer emitting lane-0 aligned ITCH message beats
// tagged with session ID and per-message sequence number.
module mold_itch_frontend #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SID_W = 80,
    parameter int SEQ_NUM_W = 64,
    parameter int ML_W = 16,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = 16'hffff
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  udp_mold_axis_tvalid,
    input  logic [AXI_KEEP_W-1:0] udp_mold_axis_tkeep,
    input  logic [AXI_DATA_W-1:0] udp_mold_axis_tdata,
    input  logic                  udp_mold_axis_tlast,
    input  logic                  udp_mold_axis_tuser,
    output logic                  mold_udp_axis_tready,
    output logic                  mold_itch_msg_v,
    output logic                  mold_itch_msg_start,
    output logic [AXI_KEEP_W-1:0] mold_itch_msg_mask,
    output logic [AXI_DATA_W-1:0] mold_itch_msg_data,
    output logic [SID_W-1:0]      mold_itch_msg_sid,
    output logic [SEQ_NUM_W-1:0]  mold_itch_msg_seq_num
);
    localparam int K = AXI_KEEP_W;
    localparam int KA = $clog2(K);
    localparam int CW = $clog2(K + 1);
    localparam int HB = (SID_W + SEQ_NUM_W + ML_W) / 8;
    localparam int HW = 8 * HB;
    localparam int BW = $clog2(HB);
    localparam int Q = 2 * K;
    localparam int QA = $clog2(Q);
    localparam logic [K-1:0] ONES = '1;

    typedef enum logic [1:0] {HDR, LEN, PAY, DRAIN} state_t;
    typedef struct packed {
        logic [SID_W-1:0]      sid;
        logic [SEQ_NUM_W-1:0]  seq;
        logic                  start;
        logic [K-1:0]          mask;
        logic [AXI_DATA_W-1:0] data;
    } beat_t;

    state_t st, n_st;
    logic [BW-1:0] bcnt, n_bcnt;
    logic [HW-1:0] hdr, n_hdr;
    logic [ML_W-1:0] len, n_len, rem, n_rem, mrem, n_mrem, mc;
    logic [SEQ_NUM_W-1:0] cur_seq, n_seq;
    logic first, n_first, rdy, acc_ok, skip, pop, hv;
    logic [AXI_DATA_W-1:0] acc, n_acc;
    logic [CW-1:0] acc_n, n_acc_n, e_n, avail;
    logic [7:0] b;
    beat_t e [K];
    beat_t q [Q];
    beat_t h;
    logic [QA-1:0] wp, rp;
    logic [QA:0] qcnt, free, n_push;

    assign mold_udp_axis_tready = rdy;
    assign acc_ok = udp_mold_axis_tvalid && rdy;

    // Walk the accepted lanes in wire order; a beat can close several output beats.
    always_comb begin
        n_st = st;
        n_bcnt = bcnt;
        n_hdr = hdr;
        n_len = len;
        n_rem = rem;
        n_mrem = mrem;
        n_seq = cur_seq;
        n_first = first;
        n_acc = acc;
        n_acc_n = acc_n;
        e_n = '0;
        b = '0;
        mc = '0;
        for (int i = 0; i < K; i++) e[i] = '0;
        if (acc_ok && udp_mold_axis_tuser) begin
            n_st = udp_mold_axis_tlast ? HDR : DRAIN;
            n_bcnt = '0;
            n_acc = '0;
            n_acc_n = '0;
        end else if (acc_ok) begin
            for (int i = 0; i < K; i++) begin
                if (udp_mold_axis_tkeep[i]) begin
                    b = udp_mold_axis_tdata[8*i +: 8];
                    if (n_st == HDR) begin
                        n_hdr[8*n_bcnt +: 8] = b;
                        if (n_bcnt == BW'(HB - 1)) begin
                            mc = n_hdr[HW-1 -: ML_W];
                            n_bcnt = '0;
                            n_seq = n_hdr[SID_W +: SEQ_NUM_W];
                            n_mrem = mc;
                            n_st = (mc == '0 || mc == EOS_MSG_CNT) ? DRAIN : LEN;
                        end else n_bcnt = n_bcnt + 1'b1;
                    end else if (n_st == LEN) begin
                        n_len[8*n_bcnt[0] +: 8] = b;
                        if (n_bcnt[0]) begin
                            n_bcnt = '0;
                            if (n_len == '0) begin
                                n_seq = n_seq + 1'b1;
                                n_mrem = n_mrem - 1'b1;
                                n_st = (n_mrem == '0) ? DRAIN : LEN;
                            end else begin
                                n_rem = n_len;
                                n_first = 1'b1;
                                n_st = PAY;
                            end
                        end else n_bcnt = BW'(1);
                    end else if (n_st == PAY) begin
                        n_acc[8*n_acc_n +: 8] = b;
                        n_acc_n = n_acc_n + 1'b1;
                        n_rem = n_rem - 1'b1;
                        if (n_acc_n == CW'(K) || n_rem == '0) begin
                            e[e_n[KA-1:0]] = '{n_hdr[SID_W-1:0], n_seq, n_first, ONES >> (CW'(K) - n_acc_n), n_acc};
                            e_n = e_n + 1'b1;
                            n_first = 1'b0;
                            n_acc = '0;
                            n_acc_n = '0;
                        end
                        if (n_rem == '0) begin
                            n_seq = n_seq + 1'b1;
                            n_mrem = n_mrem - 1'b1;
                            n_st = (n_mrem == '0) ? DRAIN : LEN;
                        end
                    end
                end
            end
            if (udp_mold_axis_tlast) begin
                if (n_st == PAY && n_acc_n != '0) begin
                    e[e_n[KA-1:0]] = '{n_hdr[SID_W-1:0], n_seq, n_first, ONES >> (CW'(K) - n_acc_n), n_acc};
                    e_n = e_n + 1'b1;
                end
                n_st = HDR;
                n_bcnt = '0;
                n_acc = '0;
                n_acc_n = '0;
            end
        end
    end

    // Output list is queue contents followed by this cycle's new beats; the head bypasses an empty queue.
    assign pop = qcnt != '0;
    assign hv = pop || e_n != '0;
    assign h = pop ? q[rp] : e[0];
    assign skip = !pop && e_n != '0;
    assign avail = e_n - CW'(skip);
    assign free = (QA+1)'(Q) - qcnt;
    assign n_push = ((QA+1)'(avail) < free) ? (QA+1)'(avail) : free;

    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++)
            if ((QA+1)'(i) < n_push) q[wp + QA'(i)] <= e[KA'(i) + KA'(skip)];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            st <= HDR;
            bcnt <= '0;
            hdr <= '0;
            len <= '0;
            rem <= '0;
            mrem <= '0;
            cur_seq <= '0;
            first <= 1'b0;
            acc <= '0;
            acc_n <= '0;
            wp <= '0;
            rp <= '0;
            qcnt <= '0;
            rdy <= 1'b0;
            mold_itch_msg_v <= 1'b0;
            mold_itch_msg_start <= 1'b0;
            mold_itch_msg_mask <= '0;
            mold_itch_msg_data <= '0;
            mold_itch_msg_sid <= '0;
            mold_itch_msg_seq_num <= '0;
        end else begin
            st <= n_st;
            bcnt <= n_bcnt;
            hdr <= n_hdr;
            len <= n_len;
            rem <= n_rem;
            mrem <= n_mrem;
            cur_seq <= n_seq;
            first <= n_first;
            acc <= n_acc;
            acc_n <= n_acc_n;
            wp <= wp + QA'(n_push);
            rp <= rp + QA'(pop);
            qcnt <= qcnt - (QA+1)'(pop) + n_push;
            rdy <= 1'b1;
            mold_itch_msg_v <= hv;
            mold_itch_msg_start <= hv ? h.start : 1'b0;
            mold_itch_msg_mask <= hv ? h.mask : '0;
            mold_itch_msg_data <= hv ? h.data : '0;
            mold_itch_msg_sid <= hv ? h.sid : '0;
            mold_itch_msg_seq_num <= hv ? h.seq : '0;
        end
    end
endmodule

// File: tb/tb_mold_itch_frontend.sv
// tb_mold_itch_frontend: directed packets against a scoreboard of expected message beats.
module tb_mold_itch_frontend;
    logic clk = 1'b0, nreset = 1'b0;
    logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
    logic [7:0] tkeep = '0;
    logic [63:0] tdata = '0;
    logic tready, msg_v, msg_start;
    logic [7:0] msg_mask;
    logic [63:0] msg_data, msg_seq;
    logic [79:0] msg_sid;

    typedef struct packed {
        logic [79:0] sid;
        logic [63:0] seq;
        logic        start;
        logic [7:0]  mask;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    logic [7:0] pkt[$];
    int total = 0, bad = 0;

    localparam logic [79:0] SA = 80'hDEADBEEF;
    localparam logic [63:0] SQA = 64'hF0F0F0F0F0F0F0F0;

    mold_itch_frontend dut (
        .clk(clk), .nreset(nreset),
        .udp_mold_axis_tvalid(tvalid), .udp_mold_axis_tkeep(tkeep),
        .udp_mold_axis_tdata(tdata), .udp_mold_axis_tlast(tlast),
        .udp_mold_axis_tuser(tuser), .mold_udp_axis_tready(tready),
        .mold_itch_msg_v(msg_v), .mold_itch_msg_start(msg_start),
        .mold_itch_msg_mask(msg_mask), .mold_itch_msg_data(msg_data),
        .mold_itch_msg_sid(msg_sid), .mold_itch_msg_seq_num(msg_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nreset && msg_v) begin
            if (sb.size() == 0) chk("spurious_v", 256'(msg_v), 256'(0));
            else begin
                mx = sb.pop_front();
                chk("msg_beat", 256'({msg_sid, msg_seq, msg_start, msg_mask, msg_data}), 256'(mx));
            end
        end
    end

    task automatic push_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) pkt.push_back(v);
    endtask

    task automatic hdr(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
        for (int i = 0; i < 10; i++) pkt.push_back(sid[8*i +: 8]);
        for (int i = 0; i < 8; i++) pkt.push_back(seq[8*i +: 8]);
        pkt.push_back(cnt[7:0]);
        pkt.push_back(cnt[15:8]);
    endtask

    task automatic add_msg(input int len, input logic [7:0] seed, input logic [63:0] seq, input logic [79:0] sid);
        exp_t x;
        int k;
        logic [7:0] v;
        logic [15:0] l16;
        l16 = 16'(len);
        pkt.push_back(l16[7:0]);
        pkt.push_back(l16[15:8]);
        x = '0;
        x.sid = sid;
        x.seq = seq;
        x.start = 1'b1;
        k = 0;
        for (int j = 0; j < len; j++) begin
            v = seed + 8'(j);
            pkt.push_back(v);
            x.data[8*k +: 8] = v;
            x.mask[k] = 1'b1;
            k++;
            if (k == 8 || j == len - 1) begin
                sb.push_back(x);
                x.data = '0;
                x.mask = '0;
                x.start = 1'b0;
                k = 0;
            end
        end
    endtask

    task automatic send_pkt(input bit sparse, input int ub, input int nb);
        int bi;
        logic [7:0] kp;
        logic [63:0] d;
        bi = 0;
        while (pkt.size() > 0 && (nb < 0 || bi < nb)) begin
            kp = '0;
            d = {$urandom, $urandom};
            for (int l = 0; l < 8; l++) begin
                if (pkt.size() > 0 && (!sparse || $urandom_range(0, 2) != 0)) begin
                    d[8*l +: 8] = pkt.pop_front();
                    kp[l] = 1'b1;
                end
            end
            tvalid = 1'b1;
            tkeep = kp;
            tdata = d;
            tlast = pkt.size() == 0;
            tuser = bi == ub;
            @(posedge clk);
            #1;
            bi++;
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        tuser = 1'b0;
        tkeep = '0;
        tdata = '0;
    endtask

    task automatic wait_sb(input string tag);
        for (int c = 0; c < 60 && sb.size() > 0; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk(tag, 256'(sb.size()), 256'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 256'(tready), 256'(0));
        chk("rst_v", 256'(msg_v), 256'(0));
        chk("rst_start", 256'(msg_start), 256'(0));
        chk("rst_mask", 256'(msg_mask), 256'(0));
        chk("rst_data", 256'(msg_data), 256'(0));
        chk("rst_sid", 256'(msg_sid), 256'(0));
        chk("rst_seq", 256'(msg_seq), 256'(0));
        nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_up", 256'(tready), 256'(1));

        // Straddling fields, multi-beat message, truncation by tlast
        hdr(SA, SQA, 16'd3);
        pkt.push_back(8'h10); pkt.push_back(8'h00);
        push_n(8'hFF, 2); push_n(8'hAA, 8); push_n(8'hBB, 6);
        pkt.push_back(8'h08); pkt.push_back(8'h00);
        push_n(8'hDD, 8);
        pkt.push_back(8'h0B); pkt.push_back(8'h00);
        push_n(8'hEE, 6); push_n(8'hFF, 4);
        sb.push_back('{sid: SA, seq: SQA, start: 1'b1, mask: 8'hFF, data: {48'hAAAAAAAAAAAA, 16'hFFFF}});
        sb.push_back('{sid: SA, seq: SQA, start: 1'b0, mask: 8'hFF, data: {48'hBBBBBBBBBBBB, 16'hAAAA}});
        sb.push_back('{sid: SA, seq: SQA + 64'd1, start: 1'b1, mask: 8'hFF, data: 64'hDDDDDDDDDDDDDDDD});
        sb.push_back('{sid: SA, seq: SQA + 64'd2, start: 1'b1, mask: 8'hFF, data: {16'hFFFF, 48'hEEEEEEEEEEEE}});
        sb.push_back('{sid: SA, seq: SQA + 64'd2, start: 1'b0, mask: 8'h03, data: 64'h000000000000FFFF});
        send_pkt(1'b0, -1, -1);
        wait_sb("drain_plan");

        // End-of-session header: nothing emitted
        hdr(80'h1111, 64'd5, 16'hFFFF);
        pkt.push_back(8'h04); pkt.push_back(8'h00); push_n(8'h99, 4);
        send_pkt(1'b0, -1, -1);
        // Zero message count: trailing bytes ignored
        hdr(80'h2222, 64'd6, 16'd0);
        pkt.push_back(8'h02); pkt.push_back(8'h00); push_n(8'h98, 2);
        send_pkt(1'b0, -1, -1);
        wait_sb("drain_eos");

        // Sparse keep, zero-length message, sequence wrap, drained tail
        hdr(80'h0123456789ABCDEF0011, 64'hFFFFFFFFFFFFFFFF, 16'd3);
        add_msg(3, 8'h10, 64'hFFFFFFFFFFFFFFFF, 80'h0123456789ABCDEF0011);
        pkt.push_back(8'h00); pkt.push_back(8'h00);
        add_msg(9, 8'h20, 64'd1, 80'h0123456789ABCDEF0011);
        push_n(8'h05, 3);
        send_pkt(1'b1, -1, -1);
        wait_sb("drain_sparse");

        // Upstream error on the first payload beat kills the packet
        hdr(80'h3333, 64'd9, 16'd2);
        pkt.push_back(8'h0A); pkt.push_back(8'h00); push_n(8'h44, 10);
        pkt.push_back(8'h03); pkt.push_back(8'h00); push_n(8'h45, 3);
        send_pkt(1'b0, 2, -1);
        hdr(80'h0102030405060708090A, 64'd100, 16'd2);
        add_msg(5, 8'h30, 64'd100, 80'h0102030405060708090A);
        add_msg(20, 8'h50, 64'd101, 80'h0102030405060708090A);
        send_pkt(1'b0, -1, -1);
        wait_sb("drain_tuser");

        // Reset while a message is mid-payload
        hdr(80'hCAFE, 64'd7, 16'd1);
        pkt.push_back(8'd40); pkt.push_back(8'h00);
        push_n(8'h66, 2); push_n(8'h77, 8); push_n(8'h88, 30);
        send_pkt(1'b0, -1, 4);
        chk("v_before_rst", 256'(msg_v), 256'(1));
        chk("data_before_rst", 256'(msg_data), 256'({48'h777777777777, 16'h6666}));
        pkt.delete();
        nreset = 1'b0;
        #1;
        chk("midrst_v", 256'(msg_v), 256'(0));
        chk("midrst_data", 256'(msg_data), 256'(0));
        chk("midrst_tready", 256'(tready), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;
        hdr(80'h5A5A, 64'h1234, 16'd1);
        add_msg(8, 8'hC0, 64'h1234, 80'h5A5A);
        send_pkt(1'b0, -1, -1);
        wait_sb("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
